imem_read_arbiter: RTL and testbench

//  Shares the single asynchronous read port of the instruction ROM between two requesters:
//  - IF stage fetch (IF)
//  - data-side read of the text region (DM): constant loads and debug reads.

---
 rtl/imem_read_arbiter.sv | 109 ++++++++++
 tb/tb_imem_read_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_read_arbiter.sv
`default_nettype none
// ============================================================================
// imem_read_arbiter : shares the instruction ROM read port between IF and DM
// Revision 1.0
// ============================================================================
module imem_read_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_req_ready,
   input  logic                  if_flush,
   output logic                  if_rsp_valid,
   output logic [31:0]           if_rsp_data,
   output logic                  if_rsp_err,
   input  logic                  dm_req_valid,
   input  logic [ADDR_WIDTH-1:0] dm_req_addr,
   output logic                  dm_req_ready,
   output logic                  dm_rsp_valid,
   output logic [31:0]           dm_rsp_data,
   output logic                  dm_rsp_err,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]           rom_rdata
);

   localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

   logic                  w_if_ok;
   logic                  w_force_dm;
   logic                  w_dm_grant;
   logic                  w_if_grant;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_err;
   logic [31:0]           w_data;

   logic [3:0]            r_starve_cnt;
   logic                  r_if_slot_valid;
   logic                  r_if_slot_err;
   logic [31:0]           r_if_slot_data;
   logic                  r_dm_slot_valid;
   logic                  r_dm_slot_err;
   logic [31:0]           r_dm_slot_data;

   // IF has priority unless flushed or DM has waited STARVE_LIMIT cycles
   always_comb begin
      w_if_ok    = if_req_valid & ~if_flush;
      w_force_dm = (r_starve_cnt == C_STARVE_LIMIT);
      w_dm_grant = dm_req_valid & (w_force_dm | ~w_if_ok);
      w_if_grant = w_if_ok & ~w_dm_grant;
      w_addr     = '0;
      if (w_dm_grant) begin
         w_addr = dm_req_addr;
      end else if (w_if_grant) begin
         w_addr = if_req_addr;
      end
      w_err  = (w_addr[1:0] != 2'b00);
      w_data = w_err ? 32'h0 : rom_rdata;
   end

   assign rom_addr     = w_addr;
   assign if_req_ready = w_if_grant;
   assign dm_req_ready = w_dm_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (!dm_req_valid || w_dm_grant) begin
         r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != C_STARVE_LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   // Slot valid is a one-cycle pulse; data/err keep the last captured word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_slot_valid <= 1'b0;
         r_if_slot_err   <= 1'b0;
         r_if_slot_data  <= 32'h0;
         r_dm_slot_valid <= 1'b0;
         r_dm_slot_err   <= 1'b0;
         r_dm_slot_data  <= 32'h0;
      end else begin
         r_if_slot_valid <= w_if_grant;
         r_dm_slot_valid <= w_dm_grant;
         if (w_if_grant) begin
            r_if_slot_err  <= w_err;
            r_if_slot_data <= w_data;
         end
         if (w_dm_grant) begin
            r_dm_slot_err  <= w_err;
            r_dm_slot_data <= w_data;
         end
      end
   end

   // A flush squashes an IF response that lands in the same cycle
   assign if_rsp_valid = r_if_slot_valid & ~if_flush;
   assign if_rsp_data  = r_if_slot_data;
   assign if_rsp_err   = r_if_slot_err;
   assign dm_rsp_valid = r_dm_slot_valid;
   assign dm_rsp_data  = r_dm_slot_data;
   assign dm_rsp_err   = r_dm_slot_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_read_arbiter.sv
`default_nettype none
// ============================================================================
// tb_imem_read_arbiter : directed table plus corner sequences for the arbiter
// Revision 1.0
// ============================================================================
module tb_imem_read_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req_valid;
   logic [11:0] if_req_addr;
   logic        if_req_ready;
   logic        if_flush;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        dm_req_valid;
   logic [11:0] dm_req_addr;
   logic        dm_req_ready;
   logic        dm_rsp_valid;
   logic [31:0] dm_rsp_data;
   logic        dm_rsp_err;
   logic [11:0] rom_addr;
   logic [31:0] rom_rdata;

   int checks = 0;
   int errors = 0;

   // ROM model: each word carries its own byte address
   assign rom_rdata = {20'hC0DE0, rom_addr};

   imem_read_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready),
      .if_flush     (if_flush),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .if_rsp_err   (if_rsp_err),
      .dm_req_valid (dm_req_valid),
      .dm_req_addr  (dm_req_addr),
      .dm_req_ready (dm_req_ready),
      .dm_rsp_valid (dm_rsp_valid),
      .dm_rsp_data  (dm_rsp_data),
      .dm_rsp_err   (dm_rsp_err),
      .rom_addr     (rom_addr),
      .rom_rdata    (rom_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_v;  logic [11:0] if_a; logic fl; logic dm_v; logic [11:0] dm_a;
      logic        if_rdy; logic dm_rdy; logic [11:0] rom;
      logic        if_rv; logic [31:0] if_rd; logic if_re;
      logic        dm_rv; logic [31:0] dm_rd; logic dm_re;
   } vec_t;

   vec_t tbl [18];

   // Protocol tracking for the requester-side hold rule
   logic        if_hold, dm_hold;
   logic [11:0] if_hold_addr, dm_hold_addr;

   // Model of the response slots used by the hand-written sequences
   logic        pig, lie, pdg, lde;
   logic [31:0] lid, ldd;

   function automatic logic [31:0] w(input logic [11:0] a);
      return {20'hC0DE0, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [11:0] ia, input logic fl,
                        input logic dv, input logic [11:0] da);
      assert (!if_hold || (iv && ia == if_hold_addr))
         else $error("IF request withdrawn or changed while waiting");
      assert (!dm_hold || (dv && da == dm_hold_addr))
         else $error("DM request withdrawn or changed while waiting");
      if_req_valid = iv; if_req_addr = ia; if_flush = fl;
      dm_req_valid = dv; dm_req_addr = da;
   endtask

   task automatic check_out(input string nm, input logic eir, input logic edr, input logic [11:0] erom,
                            input logic eirv, input logic [31:0] eird, input logic eire,
                            input logic edrv, input logic [31:0] edrd, input logic edre);
      chk({nm, " grant"},  64'({if_req_ready, dm_req_ready, rom_addr}), 64'({eir, edr, erom}));
      chk({nm, " if_rsp"}, 64'({if_rsp_valid, if_rsp_err, if_rsp_data}), 64'({eirv, eire, eird}));
      chk({nm, " dm_rsp"}, 64'({dm_rsp_valid, dm_rsp_err, dm_rsp_data}), 64'({edrv, edre, edrd}));
      if_hold = if_req_valid & ~if_req_ready; if_hold_addr = if_req_addr;
      dm_hold = dm_req_valid & ~dm_req_ready; dm_hold_addr = dm_req_addr;
   endtask

   task automatic step(input string nm, input logic iv, input logic [11:0] ia, input logic fl,
                       input logic dv, input logic [11:0] da, input logic eig, input logic edg);
      logic [11:0] erom;
      @(negedge clk);
      drive(iv, ia, fl, dv, da);
      #1;
      erom = edg ? da : (eig ? ia : 12'h000);
      check_out(nm, eig, edg, erom, pig & ~fl, lid, lie, pdg, ldd, lde);
      if (eig) begin lie = (ia[1:0] != 2'b00); lid = lie ? 32'h0 : w(ia); end
      if (edg) begin lde = (da[1:0] != 2'b00); ldd = lde ? 32'h0 : w(da); end
      pig = eig; pdg = edg;
   endtask

   // Both requesters contend; DM must win exactly every 5th cycle, then IF drains
   task automatic contend(input string nm, input int n, input logic [11:0] ia0, input logic [11:0] da0);
      logic [11:0] ia, da;
      logic dv, dg;
      ia = ia0; da = da0;
      for (int k = 0; k <= n; k++) begin
         dv = (k < n);
         dg = dv && ((k % 5) == 4);
         step($sformatf("%s%0d", nm, k), 1'b1, ia, 1'b0, dv, da, !dg, dg);
         if (dg) da = da + 12'd4;
         else    ia = ia + 12'd4;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 0,32'h0,0,         0,32'h0,0};
      tbl[1]  = '{1,12'h000,0,0,12'h000, 1,0,12'h000, 0,32'h0,0,         0,32'h0,0};
      tbl[2]  = '{1,12'h004,0,0,12'h000, 1,0,12'h004, 1,32'hC0DE0000,0,  0,32'h0,0};
      tbl[3]  = '{1,12'h008,0,0,12'h000, 1,0,12'h008, 1,32'hC0DE0004,0,  0,32'h0,0};
      tbl[4]  = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 1,32'hC0DE0008,0,  0,32'h0,0};
      tbl[5]  = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 0,32'hC0DE0008,0,  0,32'h0,0};
      tbl[6]  = '{0,12'h000,0,1,12'h006, 0,1,12'h006, 0,32'hC0DE0008,0,  0,32'h0,0};
      tbl[7]  = '{1,12'h00C,0,0,12'h000, 1,0,12'h00C, 0,32'hC0DE0008,0,  1,32'h0,1};
      tbl[8]  = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 1,32'hC0DE000C,0,  0,32'h0,1};
      tbl[9]  = '{0,12'h000,0,1,12'h100, 0,1,12'h100, 0,32'hC0DE000C,0,  0,32'h0,1};
      tbl[10] = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 0,32'hC0DE000C,0,  1,32'hC0DE0100,0};
      tbl[11] = '{1,12'h010,0,1,12'h200, 1,0,12'h010, 0,32'hC0DE000C,0,  0,32'hC0DE0100,0};
      tbl[12] = '{1,12'h014,0,1,12'h200, 1,0,12'h014, 1,32'hC0DE0010,0,  0,32'hC0DE0100,0};
      tbl[13] = '{0,12'h000,0,1,12'h200, 0,1,12'h200, 1,32'hC0DE0014,0,  0,32'hC0DE0100,0};
      tbl[14] = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 0,32'hC0DE0014,0,  1,32'hC0DE0200,0};
      tbl[15] = '{1,12'h003,0,0,12'h000, 1,0,12'h003, 0,32'hC0DE0014,0,  0,32'hC0DE0200,0};
      tbl[16] = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 1,32'h0,1,         0,32'hC0DE0200,0};
      tbl[17] = '{0,12'h000,0,0,12'h000, 0,0,12'h000, 0,32'h0,1,         0,32'hC0DE0200,0};

      if_hold = 1'b0; dm_hold = 1'b0; if_hold_addr = '0; dm_hold_addr = '0;
      rst_n = 1'b0;
      if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
      dm_req_valid = 1'b0; dm_req_addr = '0;
      repeat (2) @(negedge clk);
      #1;
      check_out("reset", 0, 0, 12'h000, 0, 32'h0, 0, 0, 32'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i].if_v, tbl[i].if_a, tbl[i].fl, tbl[i].dm_v, tbl[i].dm_a);
         #1;
         check_out($sformatf("vec%0d", i), tbl[i].if_rdy, tbl[i].dm_rdy, tbl[i].rom,
                   tbl[i].if_rv, tbl[i].if_rd, tbl[i].if_re,
                   tbl[i].dm_rv, tbl[i].dm_rd, tbl[i].dm_re);
      end

      pig = 1'b0; lid = 32'h0; lie = 1'b1;
      pdg = 1'b0; ldd = 32'hC0DE0200; lde = 1'b0;

      contend("starve", 15, 12'h080, 12'h300);

      step("flush0", 1, 12'h040, 0, 0, 12'h000, 1, 0);
      step("flush1", 1, 12'h044, 1, 1, 12'h050, 0, 1);
      step("flush2", 1, 12'h044, 0, 0, 12'h000, 1, 0);
      step("flush3", 1, 12'h048, 1, 0, 12'h000, 0, 0);
      step("flush4", 1, 12'h048, 0, 0, 12'h000, 1, 0);
      step("flush5", 0, 12'h000, 0, 0, 12'h000, 0, 0);

      // Build up DM wait count, then reset while an IF response is pending
      step("prerst0", 1, 12'h060, 0, 1, 12'h070, 1, 0);
      step("prerst1", 1, 12'h064, 0, 1, 12'h070, 1, 0);
      @(negedge clk);
      #1;
      chk("pending_if_rsp", 64'({if_rsp_valid, if_rsp_data}), 64'({1'b1, w(12'h064)}));
      rst_n = 1'b0;
      if_hold = 1'b0; dm_hold = 1'b0;
      drive(0, 12'h000, 0, 0, 12'h000);
      #1;
      chk("reset_async_if", 64'({if_rsp_valid, if_rsp_err, if_rsp_data}), 64'h0);
      chk("reset_async_dm", 64'({dm_rsp_valid, dm_rsp_err, dm_rsp_data}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_out("post_reset", 0, 0, 12'h000, 0, 32'h0, 0, 0, 32'h0, 0);
      pig = 1'b0; lid = 32'h0; lie = 1'b0;
      pdg = 1'b0; ldd = 32'h0; lde = 1'b0;
      step("post_reset_idle", 0, 12'h000, 0, 0, 12'h000, 0, 0);

      contend("rstcnt", 5, 12'h0A0, 12'h0B0);
      step("final_idle", 0, 12'h000, 0, 0, 12'h000, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
